// File: rtl/fetch_sequencer_pkg.sv
// Shared ISA constants and sequencer state encoding.
// Instruction layout: {opcode[15:12], ra[11:8], rb/imm[7:0]} where the
// three-register ops use {op, ra, rb, rc} in 4-bit fields.
package fetch_sequencer_pkg;

  localparam int OPW = 4;

  localparam logic [3:0] INST_LDI = 4'h1;
  localparam logic [3:0] INST_ADD = 4'h2;
  localparam logic [3:0] INST_SUB = 4'h3;
  localparam logic [3:0] INST_WRO = 4'h4;
  localparam logic [3:0] INST_HLT = 4'hF;

  localparam logic [3:0] REG_AX = 4'h0;
  localparam logic [3:0] REG_BX = 4'h1;
  localparam logic [3:0] REG_CX = 4'h2;

  localparam logic [15:0] INST_NOP = 16'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_STEP,
    ST_ISSUE,
    ST_HALT
  } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_prog_counter.sv
// Program counter: load / increment / hold, wraps modulo 2^AW.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   load/load_val load a new PC (wins over inc)
//   inc           advance PC by one
//   pc            registered PC
//   pc_nxt        value pc takes at the next edge (lets the parent
//                 register mem_addr in the same cycle as pc)
module prog_counter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_nxt
);

  logic [AW-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_val;
    else if (inc) pc_d = pc_q + 1'b1;  // natural wrap at 2^AW
  end

  always_ff @(posedge clk) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end

  assign pc     = pc_q;
  assign pc_nxt = pc_d;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller between program memory and the cpu.
// Fetches words with a req/ack handshake and presents each on inst for
// exactly one cycle; inst is NOP (0) otherwise. Free-run or single-step.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start, start_addr   begin execution at start_addr (from IDLE/HALT)
//   step_mode, step     hold fetched words until a step pulse
//   mem_req/addr/ack/data  program memory handshake
//   inst                instruction to cpu
//   pc, busy, halted    status
//   inst_count          instructions issued since last start (saturating)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int N   = 16,
  parameter int AW  = 8,
  parameter int OPW = fetch_sequencer_pkg::OPW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          step_mode,
  input  logic          step,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [N-1:0]  mem_data,
  output logic [N-1:0]  inst,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [15:0]   inst_count
);

  localparam logic [OPW-1:0] HLT_OP = OPW'(INST_HLT);

  fs_state_e     state_q, state_d;
  logic [N-1:0]  ir_q, ir_d;
  logic [N-1:0]  inst_q, inst_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          pc_load, pc_inc;
  logic [AW-1:0] pc_cur, pc_nxt;

  prog_counter #(.AW(AW)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (start_addr),
    .inc      (pc_inc),
    .pc       (pc_cur),
    .pc_nxt   (pc_nxt)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;

    case (state_q)
      // mem_ack is deliberately ignored here so stale acks are dropped
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_data;
          state_d = step_mode ? ST_WAIT_STEP : ST_ISSUE;
        end
      end
      ST_WAIT_STEP: begin
        if (step) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ir_q[N-1 -: OPW] == HLT_OP) begin
          state_d = ST_HALT;
        end else begin
          pc_inc  = 1'b1;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so that inst is valid
    // during the ISSUE cycle itself and mem_req/mem_addr during FETCH.
    inst_d = INST_NOP;
    if (state_d == ST_ISSUE && ir_d[N-1 -: OPW] != HLT_OP) inst_d = ir_d;

    mem_req_d  = (state_d == ST_FETCH);
    mem_addr_d = (state_d == ST_FETCH) ? pc_nxt : mem_addr_q;
    busy_d     = (state_d == ST_FETCH) || (state_d == ST_WAIT_STEP) ||
                 (state_d == ST_ISSUE);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      inst_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      inst_q     <= inst_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign inst       = inst_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign pc         = pc_cur;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: program memory model with
// configurable ack latency, issue monitor, and hand-computed expectations.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int N  = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [N-1:0]  mem_data = '0;
  logic [N-1:0]  inst;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic [15:0]   inst_count;

  fetch_sequencer #(.N(N), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .step_mode  (step_mode),
    .step       (step),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .inst       (inst),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  // program memory: ack after wait_cyc idle request cycles
  logic [N-1:0] mem [0:255];
  int   wait_cyc = 0;
  int   wcnt = 0;
  logic auto_ack = 1'b0;
  logic man_ack = 1'b0;
  logic mem_auto = 1'b1;
  assign mem_ack = mem_auto ? auto_ack : man_ack;

  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= wait_cyc) begin
        auto_ack = 1'b1;
        mem_data = mem[mem_addr];
        wcnt     = 0;
      end else begin
        auto_ack = 1'b0;
        wcnt++;
      end
    end else begin
      auto_ack = 1'b0;
      wcnt     = 0;
    end
  end

  // issue monitor
  logic [N-1:0]  issued[$];
  int            icyc[$];
  int            cyc = 0;
  int            b2b = 0;
  int            glitch = 0;
  logic          prev_nz = 1'b0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inst != '0) begin
      issued.push_back(inst);
      icyc.push_back(cyc);
      if (prev_nz) b2b++;
    end
    if (mem_req && prev_req && mem_addr != prev_addr) glitch++;
    prev_nz   = (inst != '0);
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] iss(input int i);
    return (i < issued.size()) ? issued[i] : 16'hDEAD;
  endfunction

  function automatic int icy(input int i);
    return (i < icyc.size()) ? icyc[i] : -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    start_addr = a;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_halted"}, halted, 1);
  endtask

  task automatic load_prog1();
    mem[0] = {INST_LDI, REG_AX, 8'd42};   // 102A
    mem[1] = {INST_WRO, REG_AX, 8'd0};    // 4000
    mem[2] = 16'hF000;
  endtask

  int base, g0, b0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset state
    tick(3);
    chk("rst_inst", inst, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", inst_count, 0);
    rst = 1'b1;
    tick(1);

    // free run, zero-wait memory
    load_prog1();
    wait_cyc = 0;
    base = issued.size();
    b0 = b2b;
    pulse_start(8'h00);
    wait_halt("zw", 100);
    chk("zw_n", issued.size() - base, 2);
    chk("zw_i0", iss(base), 16'h102A);
    chk("zw_i1", iss(base + 1), 16'h4000);
    chk("zw_rate", icy(base + 1) - icy(base), 2);
    chk("zw_cnt", inst_count, 2);
    chk("zw_pc", pc, 2);
    chk("zw_busy", busy, 0);
    chk("zw_inst", inst, 0);
    chk("zw_b2b", b2b - b0, 0);

    // wait-state memory, restarted from HALT
    mem[0] = {INST_LDI, REG_AX, 8'd20};          // 1014
    mem[1] = {INST_LDI, REG_BX, 8'd3};           // 1103
    mem[2] = {INST_ADD, REG_AX, REG_BX, REG_CX}; // 2012
    mem[3] = {INST_WRO, REG_CX, 8'd0};           // 4200
    mem[4] = 16'hF000;
    wait_cyc = 3;
    base = issued.size();
    g0 = glitch;
    b0 = b2b;
    pulse_start(8'h00);
    wait_halt("ws", 200);
    chk("ws_n", issued.size() - base, 4);
    chk("ws_i0", iss(base), 16'h1014);
    chk("ws_i1", iss(base + 1), 16'h1103);
    chk("ws_i2", iss(base + 2), 16'h2012);
    chk("ws_i3", iss(base + 3), 16'h4200);
    chk("ws_rate", icy(base + 1) - icy(base), 5);
    chk("ws_cnt", inst_count, 4);
    chk("ws_pc", pc, 4);
    chk("ws_addr_stable", glitch - g0, 0);
    chk("ws_b2b", b2b - b0, 0);

    // single-step
    mem[0] = {INST_LDI, REG_AX, 8'd19};          // 1013
    mem[1] = {INST_LDI, REG_BX, 8'd3};           // 1103
    mem[2] = {INST_SUB, REG_AX, REG_BX, REG_CX}; // 3012
    mem[3] = {INST_WRO, REG_CX, 8'd0};           // 4200
    mem[4] = 16'hF000;
    wait_cyc = 2;
    step_mode = 1'b1;
    base = issued.size();
    pulse_start(8'h00);
    tick(8);
    chk("ss_busy0", busy, 1);
    chk("ss_inst0", inst, 0);
    chk("ss_n0", issued.size() - base, 0);
    pulse_step();
    tick(1);
    pulse_step();            // lands in FETCH: must be dropped
    tick(8);
    chk("ss_n1", issued.size() - base, 1);
    chk("ss_cnt1", inst_count, 1);
    chk("ss_busy1", busy, 1);
    chk("ss_inst1", inst, 0);
    for (int k = 0; k < 3; k++) begin
      pulse_step();
      tick(8);
    end
    chk("ss_n4", issued.size() - base, 4);
    chk("ss_i0", iss(base), 16'h1013);
    chk("ss_i2", iss(base + 2), 16'h3012);
    chk("ss_i3", iss(base + 3), 16'h4200);
    chk("ss_cnt4", inst_count, 4);
    chk("ss_halt_pre", halted, 0);
    pulse_step();
    tick(3);
    chk("ss_halted", halted, 1);
    chk("ss_cnt_hlt", inst_count, 4);
    chk("ss_n_hlt", issued.size() - base, 4);
    chk("ss_busy_hlt", busy, 0);
    step_mode = 1'b0;

    // PC wrap
    wait_cyc = 0;
    mem[255] = {INST_LDI, REG_AX, 8'd1};         // 1001
    mem[0]   = 16'hF000;
    base = issued.size();
    pulse_start(8'hFF);
    chk("wr_pc0", pc, 8'hFF);
    wait_halt("wr", 100);
    chk("wr_pc", pc, 0);
    chk("wr_cnt", inst_count, 1);
    chk("wr_i0", iss(base), 16'h1001);

    // reset while a fetch is outstanding, then a late ack
    mem_auto = 1'b0;
    man_ack  = 1'b0;
    pulse_start(8'h10);
    tick(2);
    chk("rf_req", mem_req, 1);
    chk("rf_addr", mem_addr, 8'h10);
    chk("rf_busy", busy, 1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    man_ack = 1'b1;
    chk("rf_req0", mem_req, 0);
    chk("rf_inst0", inst, 0);
    chk("rf_busy0", busy, 0);
    chk("rf_pc0", pc, 0);
    tick(2);
    chk("rf_late_busy", busy, 0);
    chk("rf_late_req", mem_req, 0);
    chk("rf_late_pc", pc, 0);
    chk("rf_late_cnt", inst_count, 0);
    man_ack  = 1'b0;
    mem_auto = 1'b1;

    // start while busy (held across the ack cycle), then restart from HALT
    for (int i = 0; i < 256; i++) mem[i] = '0;
    load_prog1();
    wait_cyc = 3;
    base = issued.size();
    pulse_start(8'h00);
    start_addr = 8'h80;
    start = 1'b1;
    tick(5);
    start = 1'b0;
    wait_halt("sb", 200);
    chk("sb_n", issued.size() - base, 2);
    chk("sb_i0", iss(base), 16'h102A);
    chk("sb_pc", pc, 2);
    chk("sb_cnt", inst_count, 2);
    pulse_start(8'h00);
    chk("rs_halted", halted, 0);
    chk("rs_busy", busy, 1);
    chk("rs_cnt0", inst_count, 0);
    wait_halt("rs", 200);
    chk("rs_cnt", inst_count, 2);
    chk("rs_pc", pc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
